// File: rtl/down_counter_timer_if.sv
// Control/status bundle for down_counter_timer.
// master = the block driving the timer controls, slave = the timer itself.
// Optional done_count status exists only when TIMER_DONE_COUNT_EN is defined.
interface down_counter_timer_if #(
   parameter int N = 9
);
   logic         load;
   logic [N-1:0] load_value;
   logic         start;
   logic         stop;
   logic         pause;
   logic         auto_reload;
   logic [N-1:0] count;
   logic         busy;
   logic         done;
`ifdef TIMER_DONE_COUNT_EN
   logic [15:0]  done_count;
`endif

   modport master (
      output load, load_value, start, stop, pause, auto_reload,
      input  count, busy, done
`ifdef TIMER_DONE_COUNT_EN
      , input done_count
`endif
   );

   modport slave (
      input  load, load_value, start, stop, pause, auto_reload,
      output count, busy, done
`ifdef TIMER_DONE_COUNT_EN
      , output done_count
`endif
   );
endinterface

// File: rtl/down_counter_timer.sv
// Loadable N-bit down-counter timer: start/stop/pause, one-cycle done pulse on
// terminal count, optional auto-reload from the last loaded interval.
// Optional feature macro: TIMER_DONE_COUNT_EN adds a saturating 16-bit count of
// done pulses (cleared by rst only).
module down_counter_timer #(
   parameter int N = 9
) (
   input  logic                  clk,
   input  logic                  rst,
   down_counter_timer_if.slave   bus
);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t       state_q, state_d;
   logic [N-1:0] count_q, count_d;
   logic [N-1:0] reload_q, reload_d;
   logic         done_q, done_d;
   logic [N-1:0] start_val;

   // Next-state / next-count: IDLE handles load/start, RUN handles stop > pause > decrement.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      reload_d  = reload_q;
      done_d    = 1'b0;
      start_val = bus.load ? bus.load_value : count_q;
      case (state_q)
         S_IDLE: begin
            if (bus.load) begin
               reload_d = bus.load_value;
               count_d  = bus.load_value;
            end
            if (bus.start) begin
               if (start_val != '0) begin
                  state_d = S_RUN;
                  count_d = start_val;
               end else begin
                  // zero-length interval completes immediately
                  done_d = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (bus.stop) begin
               state_d = S_IDLE;
            end else if (bus.pause) begin
               state_d = S_RUN;
            end else if (count_q == N'(1)) begin
               done_d = 1'b1;
               // a zero reload value would loop with no interval, so it ends the run
               if (bus.auto_reload && (reload_q != '0)) begin
                  count_d = reload_q;
               end else begin
                  count_d = '0;
                  state_d = S_IDLE;
               end
            end else if (count_q == '0) begin
               // unreachable in normal use; never wrap below zero
               state_d = S_IDLE;
            end else begin
               count_d = count_q - N'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, count, reload and done registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         count_q  <= '0;
         reload_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         done_q   <= done_d;
      end
   end

   assign bus.count = count_q;
   assign bus.busy  = (state_q == S_RUN);
   assign bus.done  = done_q;

`ifdef TIMER_DONE_COUNT_EN
   logic [15:0] done_cnt_q, done_cnt_d;

   // Count done pulses on the same edge that raises done; saturate at all-ones.
   always_comb begin
      done_cnt_d = done_cnt_q;
      if (done_d && (done_cnt_q != 16'hFFFF)) done_cnt_d = done_cnt_q + 16'd1;
   end

   // Done-pulse counter register; only rst clears it.
   always_ff @(posedge clk) begin
      if (rst) done_cnt_q <= '0;
      else     done_cnt_q <= done_cnt_d;
   end

   assign bus.done_count = done_cnt_q;
`endif

endmodule
